pipeline_stall_controller: RTL and testbench
============================================

// Module: pipeline_stall_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline.
//  Combines the hazard unit's hazard_detected, the EXE-stage branch decision and the multicycle SRAM handshake.
//  Drives PC enable, IF/ID enable and flush, the ID/EXE bubble, and a global freeze of EXE/MEM/WB.
//  Holds the pipeline through variable-latency memory accesses, with timeout detection and a stall counter.
// PARAMETERS
//  MEM_TIMEOUT  15  max MEM_WAIT cycles without mem_ready before ERR; 0 = timeout disabled
//  CNT_W        16  width of stall_count
// PORTS
//  clk            in   1      system clock; all state updates on rising edge
//  rst            in   1      synchronous, active-high reset
//  hazard_detected in  1      from hazard detection unit: ID instr must wait
//  branch_taken   in   1      EXE-stage branch/jump resolved taken
//  mem_access     in   1      MEM-stage instr is a load or store
//  mem_ready      in   1      SRAM controller: current access complete (1-cycle pulse)
//  pc_en          out  1      PC register load enable
//  if_id_en       out  1      IF/ID register load enable
//  if_id_flush    out  1      clear IF/ID to NOP
//  id_exe_bubble  out  1      load NOP into ID/EXE
//  pipe_freeze    out  1      hold ID/EXE, EXE/MEM, MEM/WB registers
//  mem_req        out  1      registered request to SRAM controller
//  timeout_err    out  1      sticky memory timeout flag
//  stall_count    out  CNT_W  cycles with pc_en=0 (saturating)
// BEHAVIOUR
//  State and reset
//  - States: RUN, MEM_WAIT, ERR. Internal mem_done flag; wait counter wcnt of width $clog2(MEM_TIMEOUT+1), min 1.
//  - Reset: state=RUN, mem_done=0, wcnt=0, mem_req=0, timeout_err=0, stall_count=0.
//  - During any rst cycle, all combinational outputs are 0.
//  Freeze
//  - freeze = (RUN & mem_access & ~mem_done) | MEM_WAIT | ERR.
//  - While freeze=1: pc_en=0, if_id_en=0, pipe_freeze=1, if_id_flush=0, id_exe_bubble=0.
//  Not frozen (RUN), priority branch > hazard:
//  - branch_taken=1: pc_en=1, if_id_en=1, if_id_flush=1, id_exe_bubble=1.
//    Same cycle as hazard_detected: branch wins.
//  - else hazard_detected=1: pc_en=0, if_id_en=0, id_exe_bubble=1.
//  - else: pc_en=1, if_id_en=1, all other controls 0.
//  Transitions
//  - RUN: mem_access & ~mem_done -> MEM_WAIT; wcnt<=0.
//    mem_done=1 -> mem_done<=0; the access is treated as complete and the pipeline advances.
//    mem_ready is ignored in RUN.
//  - MEM_WAIT: mem_ready=1 -> RUN; mem_done<=1.
//    Otherwise, if MEM_TIMEOUT!=0 and wcnt==MEM_TIMEOUT-1 -> ERR; timeout_err<=1.
//    Otherwise wcnt<=wcnt+1.
//    mem_ready in the same cycle as the timeout boundary: ready wins.
//  - ERR: terminal until rst. timeout_err stays 1. Pipeline stays frozen.
//  mem_req and latency
//  - mem_req is registered and equals 1 exactly while state==MEM_WAIT: it rises on the entry edge and falls on the exit edge.
//  - A memory access costs 1 + N frozen cycles, where N = number of MEM_WAIT cycles up to and including the mem_ready cycle.
//  stall_count
//  - Increments by 1 in every non-rst cycle where pc_en=0 and state!=ERR.
//  - Saturates at 2^CNT_W-1; no wrap-around.
//  Reset mid-operation
//  - rst in MEM_WAIT or ERR: next cycle is RUN with mem_req=0, timeout_err=0, counters 0.
// TESTING
//  T1 hazard_detected=1 for 1 cycle in RUN -> that cycle pc_en=0, if_id_en=0, id_exe_bubble=1;
//     stall_count 0->1; next cycle pc_en=1.
//  T2 mem_access=1, mem_ready pulsed in 3rd MEM_WAIT cycle -> freeze for 4 cycles; mem_req=1 for 3 cycles;
//     5th cycle pc_en=1 with mem_access still 1 (mem_done); stall_count=4.
//  T3 branch_taken=1 and hazard_detected=1 in the same cycle -> pc_en=1, if_id_flush=1, id_exe_bubble=1;
//     stall_count unchanged.
//  T4 MEM_TIMEOUT=4, mem_access=1, mem_ready never -> ERR after 4 MEM_WAIT cycles; timeout_err=1;
//     pipe_freeze stays 1 for 20 more cycles; stall_count frozen.
//  T5 rst asserted in 2nd MEM_WAIT cycle -> next cycle state RUN, mem_req=0, stall_count=0;
//     late mem_ready pulse ignored.
//  T6 CNT_W=4, hazard_detected held 20 cycles -> stall_count=15 (saturated), not 4.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Merges hazard-unit stalls, EXE-stage branch redirects and the multicycle
// SRAM handshake into the PC / IF/ID / ID/EXE control signals, and freezes
// the back half of the pipeline while a memory access is outstanding.
// A memory access that never completes parks the controller in a sticky
// error state until reset.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_exe_bubble,
    output logic             pipe_freeze,
    output logic             mem_req,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    // The wait counter must hold values up to MEM_TIMEOUT-1; keep it at least
    // one bit wide so the design still elaborates with the timeout disabled.
    localparam int WCNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam logic [WCNT_W-1:0] WCNT_LAST =
        (MEM_TIMEOUT > 0) ? WCNT_W'(MEM_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              mem_done;
    logic              mem_done_next;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_next;
    logic              timeout_err_next;
    logic              freeze;

    // Freeze while a new access is starting in RUN, while waiting on the SRAM,
    // and forever once the access has timed out.
    always_comb begin
        freeze = 1'b0;
        case (state)
            RUN:      freeze = mem_access & ~mem_done;
            MEM_WAIT: freeze = 1'b1;
            ERR:      freeze = 1'b1;
            default:  freeze = 1'b1;
        endcase
    end

    // Next-state logic for the memory handshake sequencer.
    always_comb begin
        next_state       = state;
        mem_done_next    = mem_done;
        wcnt_next        = wcnt;
        timeout_err_next = timeout_err;
        case (state)
            RUN: begin
                // mem_done marks that the current MEM-stage access already
                // finished, so the same (still asserted) mem_access must not
                // start a second wait; it is consumed on the advancing cycle.
                if (mem_access && !mem_done) begin
                    next_state = MEM_WAIT;
                    wcnt_next  = '0;
                end else if (mem_done) begin
                    mem_done_next = 1'b0;
                end
            end
            MEM_WAIT: begin
                // A ready pulse on the timeout boundary still completes the access.
                if (mem_ready) begin
                    next_state    = RUN;
                    mem_done_next = 1'b1;
                end else if (TIMEOUT_EN && (wcnt == WCNT_LAST)) begin
                    next_state       = ERR;
                    timeout_err_next = 1'b1;
                end else begin
                    wcnt_next = wcnt + 1'b1;
                end
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // Pipeline control outputs: freeze overrides everything, then branch
    // redirect beats a load-use hazard. All controls are idle during reset.
    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_bubble = 1'b0;
        pipe_freeze   = 1'b0;
        if (!rst) begin
            if (freeze) begin
                pipe_freeze = 1'b1;
            end else if (branch_taken) begin
                pc_en         = 1'b1;
                if_id_en      = 1'b1;
                if_id_flush   = 1'b1;
                id_exe_bubble = 1'b1;
            end else if (hazard_detected) begin
                id_exe_bubble = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end
        end
    end

    // State register; mem_req is registered so it is high exactly while in MEM_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            mem_done    <= 1'b0;
            wcnt        <= '0;
            mem_req     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= next_state;
            mem_done    <= mem_done_next;
            wcnt        <= wcnt_next;
            mem_req     <= (next_state == MEM_WAIT);
            timeout_err <= timeout_err_next;
        end
    end

    // Saturating count of cycles the PC was held, excluding the dead ERR state.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!pc_en && (state != ERR) && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller: directed scenarios followed by
// random stimulus, every cycle compared against a behavioural model.
module tb_pipeline_stall_controller;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          hazard_detected;
    logic          branch_taken;
    logic          mem_access;
    logic          mem_ready;
    logic          pc_en;
    logic          if_id_en;
    logic          if_id_flush;
    logic          id_exe_bubble;
    logic          pipe_freeze;
    logic          mem_req;
    logic          timeout_err;
    logic [CW-1:0] stall_count;

    int vectors     = 0;
    int comparisons = 0;
    int miscompares = 0;

    // Behavioural model state
    bit m_waiting;
    bit m_error;
    bit m_done;
    int m_waitCycles;
    int m_stalls;

    // Expected combinational outputs for the current cycle
    bit e_pc, e_ifid, e_flush, e_bubble, e_freeze;

    pipeline_stall_controller #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hazard_detected(hazard_detected),
        .branch_taken   (branch_taken),
        .mem_access     (mem_access),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_exe_bubble  (id_exe_bubble),
        .pipe_freeze    (pipe_freeze),
        .mem_req        (mem_req),
        .timeout_err    (timeout_err),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        comparisons++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s (vector %0d): observed=%0h expected=%0h", tag, vectors, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit frozen;
        e_pc = 0; e_ifid = 0; e_flush = 0; e_bubble = 0; e_freeze = 0;
        if (!rst) begin
            frozen = m_error || m_waiting || (mem_access && !m_done);
            if (frozen) e_freeze = 1;
            else if (branch_taken) begin
                e_pc = 1; e_ifid = 1; e_flush = 1; e_bubble = 1;
            end else if (hazard_detected) e_bubble = 1;
            else begin
                e_pc = 1; e_ifid = 1;
            end
        end
        checkValue("pc_en",         32'(pc_en),         32'(e_pc));
        checkValue("if_id_en",      32'(if_id_en),      32'(e_ifid));
        checkValue("if_id_flush",   32'(if_id_flush),   32'(e_flush));
        checkValue("id_exe_bubble", 32'(id_exe_bubble), 32'(e_bubble));
        checkValue("pipe_freeze",   32'(pipe_freeze),   32'(e_freeze));
        checkValue("mem_req",       32'(mem_req),       32'(m_waiting));
        checkValue("timeout_err",   32'(timeout_err),   32'(m_error));
        checkValue("stall_count",   32'(stall_count),   32'(m_stalls));
    endtask

    // Advance the model by one clock according to the controller's rules.
    task automatic updateModel();
        if (rst) begin
            m_waiting = 0; m_error = 0; m_done = 0; m_waitCycles = 0; m_stalls = 0;
        end else begin
            if (!e_pc && !m_error && m_stalls < MAXC) m_stalls++;
            if (m_error) begin
                // stays in error until reset
            end else if (m_waiting) begin
                if (mem_ready) begin
                    m_waiting = 0; m_done = 1;
                end else if (m_waitCycles + 1 == TO) begin
                    m_waiting = 0; m_error = 1;
                end else m_waitCycles++;
            end else if (m_done) begin
                m_done = 0;
            end else if (mem_access) begin
                m_waiting = 1; m_waitCycles = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit h, input bit b, input bit ma, input bit mr);
        @(negedge clk);
        rst = r; hazard_detected = h; branch_taken = b; mem_access = ma; mem_ready = mr;
        #1;
        vectors++;
        checkOutput();
        updateModel();
    endtask

    initial begin
        rst = 1; hazard_detected = 0; branch_taken = 0; mem_access = 0; mem_ready = 0;
        m_waiting = 0; m_error = 0; m_done = 0; m_waitCycles = 0; m_stalls = 0;

        // Reset
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("reset_count", 32'(stall_count), 32'd0);
        checkValue("reset_pc_en", 32'(pc_en), 32'd1);

        // T1: single hazard cycle
        applyStimulus(0, 1, 0, 0, 0);
        checkValue("T1_pc_en", 32'(pc_en), 32'd0);
        checkValue("T1_bubble", 32'(id_exe_bubble), 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("T1_pc_after", 32'(pc_en), 32'd1);
        checkValue("T1_count", 32'(stall_count), 32'd1);

        // T2: access with ready in third wait cycle
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkValue("T2_req_w1", 32'(mem_req), 32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkValue("T2_freeze_w3", 32'(pipe_freeze), 32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkValue("T2_pc_done", 32'(pc_en), 32'd1);
        checkValue("T2_req_done", 32'(mem_req), 32'd0);
        checkValue("T2_count", 32'(stall_count), 32'd4);
        applyStimulus(0, 0, 0, 0, 0);

        // T3: branch beats hazard
        applyStimulus(0, 1, 1, 0, 0);
        checkValue("T3_pc_en", 32'(pc_en), 32'd1);
        checkValue("T3_flush", 32'(if_id_flush), 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("T3_count", 32'(stall_count), 32'd4);

        // T4: timeout into ERR
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, i[0], i[1], 1, i[2]);
        checkValue("T4_err", 32'(timeout_err), 32'd1);
        checkValue("T4_freeze", 32'(pipe_freeze), 32'd1);
        checkValue("T4_count", 32'(stall_count), 32'd5);

        // T5: reset during MEM_WAIT, late ready ignored
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkValue("T5_req", 32'(mem_req), 32'd0);
        checkValue("T5_count", 32'(stall_count), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("T5_pc_en", 32'(pc_en), 32'd1);

        // T6: counter saturation
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkValue("T6_sat", 32'(stall_count), 32'd15);

        // Random stimulus against the model
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 39) == 0,
                          $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 20,
                          $urandom_range(0, 99) < 40,
                          $urandom_range(0, 99) < 40);
        end

        $display("[TB] %0d comparisons made", comparisons);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
